// File: rtl/piso_shift_register.sv
// -----------------------------------------------------------------------------
// piso_shift_register
//
// Purpose:
//   4-bit parallel-in / serial-out register that runs on its own timing.
//   There is no load or shift strobe.
//   A free-running 2-bit phase counter divides time into 4-cycle frames:
//     - phase 0: load {d3,d2,d1,d0}.
//     - phases 1..3: shift right by one bit.
//   Serial data leaves on out[0], LSB first.
//   Frames follow each other back to back, with no idle cycle between them.
//
// Ports:
//   clk      in   1  sole clock, rising-edge active
//   rst      in   1  asynchronous, active-high reset (out=0, phase=0)
//   d0..d3   in   1  parallel data bits; sampled only on phase-0 edges
//   out      out  4  registered shift state; out[0] is the serial output
//
// Configuration macro:
//   PISO_ROTATE_EN
//     - Defined: shift phases rotate right (the fill bit is out[0]).
//     - Undefined (default): the fill bit is 1'b0.
// -----------------------------------------------------------------------------
module piso_shift_register (
  input  logic       clk,
  input  logic       rst,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic [3:0] out
);

  logic [1:0] phase_q;
  logic [1:0] phase_d;
  logic [3:0] shift_q;
  logic [3:0] shift_d;
  logic       fill_s;

  // Bit shifted into the MSB on shift phases.
`ifdef PISO_ROTATE_EN
  assign fill_s = shift_q[0];
`else
  assign fill_s = 1'b0;
`endif

  // Next-state logic: the phase counter wraps naturally at 2 bits.
  // Phase 0 reloads the register; every other phase shifts it.
  always_comb begin
    phase_d = phase_q + 2'd1;
    shift_d = shift_q;
    if (phase_q == 2'd0) begin
      shift_d = {d3, d2, d1, d0};
    end else begin
      shift_d = {fill_s, shift_q[3:1]};
    end
  end

  // State registers.
  // The asynchronous reset dominates any coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 2'd0;
      shift_q <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
    end
  end

  assign out = shift_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_register
//
// Directed and randomized self-checking bench for piso_shift_register.
// The bench follows PISO_ROTATE_EN so that it can check either build.
// -----------------------------------------------------------------------------
module tb_piso_shift_register;

  logic       clk;
  logic       rst;
  logic       d0;
  logic       d1;
  logic       d2;
  logic       d3;
  logic [3:0] out;
  logic       clk_run;

  int checks;
  int failures;

  piso_shift_register dut (
    .clk (clk),
    .rst (rst),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .out (out)
  );

  // Gated clock: while clk_run is low, the clock stays still at 0.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges. The next edge is then a load.
  task automatic do_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulse out=%b expected=%b", out, 4'b0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clk_run = 1'b0;
    rst     = 1'b0;
    set_d(4'b1011);
    #2;
    rst = 1'b1;
    #3;
    checks++;
    if (out !== 4'b0000) begin
      failures++;
      $display("FAIL reset_no_clock out=%b expected=%b", out, 4'b0000);
    end
    #2;
    rst = 1'b0;
    #2;
    checks++;
    if (out !== 4'b0000) begin
      failures++;
      $display("FAIL reset_released_idle out=%b expected=%b", out, 4'b0000);
    end
    clk_run = 1'b1;
  endtask

  task automatic test_basic;
    logic [3:0] exp_s [5];
    logic [3:0] ser_s;
`ifdef PISO_ROTATE_EN
    exp_s[0] = 4'b1011; exp_s[1] = 4'b1101; exp_s[2] = 4'b1110;
    exp_s[3] = 4'b0111; exp_s[4] = 4'b1011;
`else
    exp_s[0] = 4'b1011; exp_s[1] = 4'b0101; exp_s[2] = 4'b0010;
    exp_s[3] = 4'b0001; exp_s[4] = 4'b1011;
`endif
    set_d(4'b1011);
    ser_s = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) ser_s[i] = out[0];
      checks++;
      if (out !== exp_s[i]) begin
        failures++;
        $display("FAIL basic_edge%0d out=%b expected=%b", i + 1, out, exp_s[i]);
      end
    end
    checks++;
    if (ser_s !== 4'b1011) begin
      failures++;
      $display("FAIL basic_serial got(d3..d0)=%b expected=%b", ser_s, 4'b1011);
    end
  endtask

  task automatic test_midframe_change;
    logic [3:0] exp_s [5];
`ifdef PISO_ROTATE_EN
    exp_s[0] = 4'b1111; exp_s[1] = 4'b1111; exp_s[2] = 4'b1111;
    exp_s[3] = 4'b1111; exp_s[4] = 4'b0000;
`else
    exp_s[0] = 4'b1111; exp_s[1] = 4'b0111; exp_s[2] = 4'b0011;
    exp_s[3] = 4'b0001; exp_s[4] = 4'b0000;
`endif
    do_reset();
    set_d(4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) set_d(4'b0000);
      checks++;
      if (out !== exp_s[i]) begin
        failures++;
        $display("FAIL midframe_edge%0d out=%b expected=%b", i + 1, out, exp_s[i]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    do_reset();
    set_d(4'b1010);
    tick();
    tick();
    checks++;
    if (out !== 4'b0101) begin
      failures++;
      $display("FAIL abort_pre out=%b expected=%b", out, 4'b0101);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 4'b0000) begin
      failures++;
      $display("FAIL abort_async out=%b expected=%b", out, 4'b0000);
    end
    tick();
    checks++;
    if (out !== 4'b0000) begin
      failures++;
      $display("FAIL abort_hold out=%b expected=%b", out, 4'b0000);
    end
    set_d(4'b0110);
    rst = 1'b0;
    tick();
    checks++;
    if (out !== 4'b0110) begin
      failures++;
      $display("FAIL abort_reload out=%b expected=%b", out, 4'b0110);
    end
    tick();
    checks++;
    if (out !== 4'b0011) begin
      failures++;
      $display("FAIL abort_shift out=%b expected=%b", out, 4'b0011);
    end
  endtask

  task automatic test_random_frames;
    logic [3:0] model_q;
    logic [3:0] word_s;
    logic [3:0] ser_s;
    logic [3:0] v;
    logic       fill;
    do_reset();
    model_q = 4'b0000;
    word_s  = 4'b0000;
    for (int f = 0; f < 40; f++) begin
      ser_s = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        v = 4'($urandom_range(0, 15));
        set_d(v);
        tick();
`ifdef PISO_ROTATE_EN
        fill = model_q[0];
`else
        fill = 1'b0;
`endif
        if (k == 0) begin
          word_s  = v;
          model_q = v;
        end else begin
          model_q = {fill, model_q[3:1]};
        end
        ser_s[k] = out[0];
        checks++;
        if (out !== model_q) begin
          failures++;
          $display("FAIL rand_out f%0d k%0d out=%b expected=%b", f, k, out, model_q);
        end
      end
      checks++;
      if (ser_s !== word_s) begin
        failures++;
        $display("FAIL rand_frame f%0d serial=%b expected=%b", f, ser_s, word_s);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk_run  = 1'b0;
    rst      = 1'b0;
    set_d(4'b0000);
    test_reset();
    test_basic();
    test_midframe_change();
    test_reset_midframe();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
